// File: rtl/async_ctl_pkg.sv
// Shared types and defaults for the async clear/preset sequencer.
// Optional round-robin arbitration is selected with ASYNC_CTL_SEQ_RR_EN.
package async_ctl_pkg;

    localparam int unsigned DEF_NREQ      = 4;
    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_PULSE_CYC = 2;
    localparam int unsigned CNT_W         = 4;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_LOAD   = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_PRESET = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PULSE   = 2'b01,
        ST_RECOVER = 2'b10
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/async_ctl_arb.sv
// Requester arbiter: fixed lowest-index priority, or a rotating search that
// starts at ptr when ASYNC_CTL_SEQ_RR_EN is defined.
module async_ctl_arb
    import async_ctl_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req,
`ifdef ASYNC_CTL_SEQ_RR_EN
    input  logic [PW-1:0]   ptr,
`endif
    output logic [NREQ-1:0] grant
);

`ifdef ASYNC_CTL_SEQ_RR_EN
    always_comb begin
        int unsigned j;
        logic        found;
        grant = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = i + {{(32-PW){1'b0}}, ptr};
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j[PW-1:0]]) begin
                grant[j[PW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end
`else
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i[PW-1:0]]) begin
                grant[i[PW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/async_ctl_seq.sv
// Sequencer that arbitrates requesters and drives load / async clear / preset
// pulses into a flop bank. ASYNC_CTL_SEQ_RR_EN selects round-robin arbitration.
module async_ctl_seq
    import async_ctl_pkg::*;
#(
    parameter int unsigned NREQ      = DEF_NREQ,
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned PULSE_CYC = DEF_PULSE_CYC
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     op,
    input  logic [WIDTH*NREQ-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      ff_clr_n,
    output logic [WIDTH-1:0]      ff_pre_n,
    output logic                  ff_en,
    output logic [WIDTH-1:0]      ff_d,
    output logic                  busy
);

    localparam int unsigned      PW        = idx_width(NREQ);
    localparam logic [CNT_W-1:0] CNT_PULSE = CNT_W'(PULSE_CYC - 1);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    op_e              op_q;
    logic [WIDTH-1:0] data_q;
    logic [NREQ-1:0]  owner_q;

    logic [NREQ-1:0]  arb_grant;
    logic             grant_fire;
    op_e              sel_op;
    logic [WIDTH-1:0] sel_data;

    logic [NREQ-1:0]  gnt_nxt, done_nxt;
    logic [WIDTH-1:0] clr_n_nxt, pre_n_nxt, d_nxt;
    logic             en_nxt, busy_nxt;

    // A grant is issued on the edge into an IDLE cycle, so gnt shows up
    // during IDLE and RECOVER can hand straight over to the next requester.
    assign grant_fire = (|req) &&
                        (((state == ST_IDLE) && !(|gnt)) || (state == ST_RECOVER));

`ifdef ASYNC_CTL_SEQ_RR_EN
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
    logic [PW-1:0] ptr, gnt_idx;

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) gnt_idx = i[PW-1:0];
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)            ptr <= '0;
        else if (grant_fire) ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end
`endif

    async_ctl_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req   (req),
`ifdef ASYNC_CTL_SEQ_RR_EN
        .ptr   (ptr),
`endif
        .grant (arb_grant)
    );

    always_comb begin
        sel_op   = OP_NOP;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                sel_op   = op_e'(op[2*i +: 2]);
                sel_data = wdata[WIDTH*i +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            op_q    <= OP_NOP;
            data_q  <= '0;
            owner_q <= '0;
        end else if (grant_fire) begin
            op_q    <= sel_op;
            data_q  <= sel_data;
            owner_q <= arb_grant;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (|gnt) begin
                    if (op_q == OP_NOP) begin
                        state_nxt = ST_RECOVER;
                    end else begin
                        state_nxt = ST_PULSE;
                        cnt_nxt   = (op_q == OP_LOAD) ? '0 : CNT_PULSE;
                    end
                end
            end
            ST_PULSE: begin
                if (cnt == '0) state_nxt = ST_RECOVER;
                else           cnt_nxt   = cnt - 1'b1;
            end
            ST_RECOVER: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so each registered value
    // lines up with the state it belongs to.
    always_comb begin
        gnt_nxt   = grant_fire ? arb_grant : '0;
        done_nxt  = (state_nxt == ST_RECOVER) ? owner_q : '0;
        en_nxt    = 1'b0;
        d_nxt     = ff_d;
        clr_n_nxt = '1;
        pre_n_nxt = '1;
        busy_nxt  = (state_nxt != ST_IDLE);
        if (state_nxt == ST_PULSE) begin
            unique case (op_q)
                OP_LOAD: begin
                    en_nxt = 1'b1;
                    d_nxt  = data_q;
                end
                OP_CLEAR:  clr_n_nxt = ~data_q;
                OP_PRESET: pre_n_nxt = ~data_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            gnt      <= '0;
            done     <= '0;
            ff_en    <= 1'b0;
            ff_d     <= '0;
            ff_clr_n <= '1;
            ff_pre_n <= '1;
            busy     <= 1'b0;
        end else begin
            gnt      <= gnt_nxt;
            done     <= done_nxt;
            ff_en    <= en_nxt;
            ff_d     <= d_nxt;
            ff_clr_n <= clr_n_nxt;
            ff_pre_n <= pre_n_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_async_ctl_seq.sv
// Self-checking bench for async_ctl_seq (default parameters; arbitration
// expectations follow ASYNC_CTL_SEQ_RR_EN when it is defined).
module tb_async_ctl_seq;
    import async_ctl_pkg::*;

    localparam int unsigned NREQ      = 4;
    localparam int unsigned WIDTH     = 8;
    localparam int unsigned PULSE_CYC = 2;
    localparam int unsigned RAND_CYC  = 10000;

    logic                  clk = 1'b0;
    logic                  clr;
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [WIDTH*NREQ-1:0] wdata;
    logic [NREQ-1:0]       gnt, done;
    logic [WIDTH-1:0]      ff_clr_n, ff_pre_n, ff_d;
    logic                  ff_en, busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int unsigned idx;
        op_e         opc;
        logic [7:0]  data;
    } txn_t;

    txn_t        sb_q[$];
    int unsigned exp_idx_q[$];

    always #5 clk = ~clk;

    async_ctl_seq #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .PULSE_CYC (PULSE_CYC)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .req      (req),
        .op       (op),
        .wdata    (wdata),
        .gnt      (gnt),
        .done     (done),
        .ff_clr_n (ff_clr_n),
        .ff_pre_n (ff_pre_n),
        .ff_en    (ff_en),
        .ff_d     (ff_d),
        .busy     (busy)
    );

    task automatic issue(input int unsigned i, input op_e o, input logic [7:0] d);
        req[i]          = 1'b1;
        op[2*i +: 2]    = o;
        wdata[8*i +: 8] = d;
        sb_q.push_back('{idx: i, opc: o, data: d});
    endtask

    task automatic wait_gnt(output bit ok);
        int n = 0;
        while (gnt === '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (gnt !== '0);
    endtask

    task automatic do_reset();
        clr = 1'b0;
        req = '0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clr = 1'b0; req = '0; op = '0; wdata = '0;
        repeat (2) @(negedge clk);
        checks++; if (gnt !== 4'b0000)    begin failures++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
        checks++; if (done !== 4'b0000)   begin failures++; $display("FAIL reset_done got=%b want=0000", done); end
        checks++; if (ff_en !== 1'b0)     begin failures++; $display("FAIL reset_ff_en got=%b want=0", ff_en); end
        checks++; if (ff_d !== 8'h00)     begin failures++; $display("FAIL reset_ff_d got=%h want=00", ff_d); end
        checks++; if (ff_clr_n !== 8'hFF) begin failures++; $display("FAIL reset_ff_clr_n got=%h want=ff", ff_clr_n); end
        checks++; if (ff_pre_n !== 8'hFF) begin failures++; $display("FAIL reset_ff_pre_n got=%h want=ff", ff_pre_n); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        clr = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clear();
        txn_t t; bit ok;
        issue(0, OP_CLEAR, 8'hF0);
        wait_gnt(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL clear_gnt_timeout got=%b want=0001", gnt); req = '0; return; end
        t = sb_q.pop_front();
        if (gnt !== 4'(1 << t.idx) || busy !== 1'b0) begin
            failures++; $display("FAIL clear_gnt got=%b busy=%b want=%b busy=0", gnt, busy, 4'(1 << t.idx));
        end
        req[0] = 1'b0;
        @(negedge clk);
        checks++; if (ff_clr_n !== 8'h0F || ff_pre_n !== 8'hFF || busy !== 1'b1) begin
            failures++; $display("FAIL clear_t1 got clr_n=%h pre_n=%h busy=%b want 0f ff 1", ff_clr_n, ff_pre_n, busy);
        end
        @(negedge clk);
        checks++; if (ff_clr_n !== 8'h0F || done !== 4'b0000) begin
            failures++; $display("FAIL clear_t2 got clr_n=%h done=%b want 0f 0000", ff_clr_n, done);
        end
        @(negedge clk);
        checks++; if (ff_clr_n !== 8'hFF || done !== 4'b0001) begin
            failures++; $display("FAIL clear_t3 got clr_n=%h done=%b want ff 0001", ff_clr_n, done);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 4'b0000) begin
            failures++; $display("FAIL clear_t4 got busy=%b done=%b want 0 0000", busy, done);
        end
    endtask

    task automatic test_load();
        txn_t t; bit ok;
        issue(2, OP_LOAD, 8'hA5);
        wait_gnt(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL load_gnt_timeout got=%b want=0100", gnt); req = '0; return; end
        t = sb_q.pop_front();
        if (gnt !== 4'(1 << t.idx)) begin failures++; $display("FAIL load_gnt got=%b want=%b", gnt, 4'(1 << t.idx)); end
        req[2] = 1'b0;
        @(negedge clk);
        checks++; if (ff_en !== 1'b1 || ff_d !== 8'hA5) begin
            failures++; $display("FAIL load_t1 got en=%b d=%h want 1 a5", ff_en, ff_d);
        end
        @(negedge clk);
        checks++; if (ff_en !== 1'b0 || done !== 4'b0100 || ff_d !== 8'hA5) begin
            failures++; $display("FAIL load_t2 got en=%b done=%b d=%h want 0 0100 a5", ff_en, done, ff_d);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL load_t3 got busy=%b want 0", busy); end
    endtask

    task automatic test_zero_mask();
        txn_t t; bit ok;
        issue(1, OP_PRESET, 8'h00);
        wait_gnt(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL zmask_gnt_timeout got=%b want=0010", gnt); req = '0; return; end
        t = sb_q.pop_front();
        if (gnt !== 4'(1 << t.idx)) begin failures++; $display("FAIL zmask_gnt got=%b want=%b", gnt, 4'(1 << t.idx)); end
        req[1] = 1'b0;
        @(negedge clk);
        checks++; if (ff_pre_n !== 8'hFF || ff_clr_n !== 8'hFF || busy !== 1'b1 || ff_en !== 1'b0) begin
            failures++; $display("FAIL zmask_t1 got pre_n=%h clr_n=%h busy=%b en=%b want ff ff 1 0", ff_pre_n, ff_clr_n, busy, ff_en);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || done !== 4'b0000) begin
            failures++; $display("FAIL zmask_t2 got busy=%b done=%b want 1 0000", busy, done);
        end
        @(negedge clk);
        checks++; if (done !== 4'b0010) begin failures++; $display("FAIL zmask_t3 got done=%b want 0010", done); end
        @(negedge clk);
    endtask

    task automatic test_recover_req();
        txn_t t; bit ok;
        issue(1, OP_NOP, 8'h00);
        wait_gnt(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rec_gnt_timeout got=%b want=0010", gnt); req = '0; return; end
        t = sb_q.pop_front();
        if (gnt !== 4'(1 << t.idx)) begin failures++; $display("FAIL rec_gnt1 got=%b want=%b", gnt, 4'(1 << t.idx)); end
        req[1] = 1'b0;
        @(negedge clk);
        checks++; if (done !== 4'b0010 || busy !== 1'b1) begin
            failures++; $display("FAIL rec_done1 got done=%b busy=%b want 0010 1", done, busy);
        end
        issue(2, OP_NOP, 8'h00);
        @(negedge clk);
        t = sb_q.pop_front();
        checks++; if (gnt !== 4'(1 << t.idx) || busy !== 1'b0) begin
            failures++; $display("FAIL rec_gnt2 got gnt=%b busy=%b want %b 0", gnt, busy, 4'(1 << t.idx));
        end
        req[2] = 1'b0;
        @(negedge clk);
        checks++; if (done !== 4'b0100) begin failures++; $display("FAIL rec_done2 got=%b want=0100", done); end
        @(negedge clk);
    endtask

    task automatic test_arb();
        int last_cyc = -1;
        int cyc      = 0;
        int seen     = 0;
        do_reset();
        exp_idx_q.delete();
        for (int unsigned k = 0; k < 5; k++) begin
`ifdef ASYNC_CTL_SEQ_RR_EN
            exp_idx_q.push_back(k % NREQ);
`else
            exp_idx_q.push_back(0);
`endif
        end
        op  = '0;
        req = 4'b1111;
        while (seen < 5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (gnt !== '0) begin
                int unsigned e = exp_idx_q.pop_front();
                checks++; if (gnt !== 4'(1 << e)) begin
                    failures++; $display("FAIL arb_order[%0d] got=%b want=%b", seen, gnt, 4'(1 << e));
                end
                if (last_cyc >= 0) begin
                    checks++; if (cyc - last_cyc != 2) begin
                        failures++; $display("FAIL arb_spacing[%0d] got=%0d want=2", seen, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                seen++;
            end
        end
        checks++; if (seen != 5) begin failures++; $display("FAIL arb_timeout got=%0d grants want=5", seen); end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_pulse();
        txn_t t; bit ok; bit bad = 0;
        issue(3, OP_PRESET, 8'hFF);
        wait_gnt(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mid_gnt_timeout got=%b want=1000", gnt); req = '0; return; end
        t = sb_q.pop_front();
        if (gnt !== 4'(1 << t.idx)) begin failures++; $display("FAIL mid_gnt got=%b want=%b", gnt, 4'(1 << t.idx)); end
        @(negedge clk);
        checks++; if (ff_pre_n !== 8'h00) begin failures++; $display("FAIL mid_pulse got pre_n=%h want 00", ff_pre_n); end
        clr = 1'b0;
        #1;
        checks++; if (ff_pre_n !== 8'hFF || busy !== 1'b0 || done !== 4'b0000 || ff_clr_n !== 8'hFF) begin
            failures++; $display("FAIL mid_abort got pre_n=%h busy=%b done=%b clr_n=%h want ff 0 0000 ff", ff_pre_n, busy, done, ff_clr_n);
        end
        req = '0;
        @(negedge clk);
        clr = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 4'b0000 || gnt !== 4'b0000) bad = 1;
        end
        checks++; if (bad) begin failures++; $display("FAIL mid_post_idle got busy=%b done=%b gnt=%b want idle", busy, done, gnt); end
    endtask

    task automatic test_back_to_back();
        txn_t t;
        int   n_gnt  = 0;
        int   n_done = 0;
        do_reset();
        for (int unsigned cyc = 0; cyc < RAND_CYC + 40; cyc++) begin
            logic [NREQ-1:0] granted = '0;
            @(negedge clk);
            checks++; if ((~ff_clr_n & ~ff_pre_n) !== 8'h00) begin
                failures++; $display("FAIL b2b_both_low cyc=%0d clr_n=%h pre_n=%h", cyc, ff_clr_n, ff_pre_n);
            end
            if (done !== '0) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++; $display("FAIL b2b_done_unexpected cyc=%0d got=%b want=none", cyc, done);
                end else begin
                    t = sb_q.pop_front();
                    n_done++;
                    if (done !== 4'(1 << t.idx)) begin
                        failures++; $display("FAIL b2b_done cyc=%0d got=%b want=%b", cyc, done, 4'(1 << t.idx));
                    end
                end
            end
            if (ff_en === 1'b1 || ff_clr_n !== 8'hFF || ff_pre_n !== 8'hFF) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++; $display("FAIL b2b_bank_idle cyc=%0d en=%b clr_n=%h pre_n=%h want quiet", cyc, ff_en, ff_clr_n, ff_pre_n);
                end else begin
                    t = sb_q[0];
                    if (ff_en === 1'b1 && (t.opc != OP_LOAD || ff_d !== t.data)) begin
                        failures++; $display("FAIL b2b_load cyc=%0d got d=%h want %h op=%0d", cyc, ff_d, t.data, t.opc);
                    end
                    if (ff_clr_n !== 8'hFF && (t.opc != OP_CLEAR || ff_clr_n !== ~t.data)) begin
                        failures++; $display("FAIL b2b_clear cyc=%0d got clr_n=%h want %h", cyc, ff_clr_n, ~t.data);
                    end
                    if (ff_pre_n !== 8'hFF && (t.opc != OP_PRESET || ff_pre_n !== ~t.data)) begin
                        failures++; $display("FAIL b2b_preset cyc=%0d got pre_n=%h want %h", cyc, ff_pre_n, ~t.data);
                    end
                end
            end
            if (gnt !== '0) begin
                checks++;
                if (!$onehot(gnt) || (gnt & ~req) !== '0 || sb_q.size() != 0) begin
                    failures++; $display("FAIL b2b_gnt cyc=%0d got=%b req=%b outstanding=%0d", cyc, gnt, req, sb_q.size());
                end
                for (int unsigned i = 0; i < NREQ; i++) begin
                    if (gnt[i]) begin
                        sb_q.push_back('{idx: i, opc: op_e'(op[2*i +: 2]), data: wdata[8*i +: 8]});
                        req[i] = 1'b0;
                    end
                end
                granted = gnt;
                n_gnt++;
            end
            if (cyc < RAND_CYC) begin
                for (int unsigned i = 0; i < NREQ; i++) begin
                    if (!req[i] && !granted[i] && $urandom_range(0, 3) == 0) begin
                        req[i]          = 1'b1;
                        op[2*i +: 2]    = 2'($urandom_range(0, 3));
                        wdata[8*i +: 8] = 8'($urandom);
                    end
                end
            end else begin
                req = '0;
            end
        end
        checks++; if (n_gnt != n_done || sb_q.size() != 0 || n_gnt == 0) begin
            failures++; $display("FAIL b2b_balance got gnt=%0d done=%0d outstanding=%0d", n_gnt, n_done, sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_load();
        test_zero_mask();
        test_recover_req();
        test_arb();
        test_reset_mid_pulse();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/async_ctl_seq.md
ASYNC_CTL_SEQ -- requirements
Module: async_ctl_seq

Interface
- REQ-001 Parameter NREQ, default 4: number of requesters.
- REQ-002 Parameter WIDTH, default 8: width of the controlled flop bank.
- REQ-003 Parameter PULSE_CYC, default 2, range 1..15: clear/preset pulse width in clk cycles.
- REQ-004 clk  in  1  single clock; all state on posedge.
- REQ-005 clr  in  1  reset, asynchronous, active-low.
- REQ-006 req  in  NREQ  per-requester request, held high until gnt.
- REQ-007 op  in  2*NREQ  per-requester opcode: 00 NOP, 01 LOAD, 10 CLEAR, 11 PRESET.
- REQ-008 wdata  in  WIDTH*NREQ  per-requester data (LOAD) or bit mask (CLEAR/PRESET).
- REQ-009 gnt  out  NREQ  one-hot, one-cycle acceptance pulse.
- REQ-010 done  out  NREQ  one-hot, one-cycle completion pulse to the granted requester.
- REQ-011 ff_clr_n  out  WIDTH  per-bit async clear to the flop bank, active-low.
- REQ-012 ff_pre_n  out  WIDTH  per-bit async preset to the flop bank, active-low.
- REQ-013 ff_en  out  1  load enable to the flop bank.
- REQ-014 ff_d  out  WIDTH  load data to the flop bank.
- REQ-015 busy  out  1  high whenever state is not IDLE.

Function
- REQ-016 FSM states: IDLE, PULSE, RECOVER; all outputs registered.
- REQ-017 In IDLE with any req high, the arbiter shall pick one index, pulse gnt for that cycle T, capture op and wdata, and leave IDLE at T+1.
- REQ-018 LOAD: PULSE at T+1 with ff_en=1 and ff_d=captured data for exactly 1 cycle; RECOVER at T+2.
- REQ-019 CLEAR: PULSE from T+1 for PULSE_CYC cycles with ff_clr_n = ~mask; RECOVER at T+1+PULSE_CYC.
- REQ-020 PRESET: as CLEAR, but with ff_pre_n = ~mask.
- REQ-021 NOP: go straight to RECOVER at T+1 with no flop-bank activity.
- REQ-022 RECOVER lasts 1 cycle with ff_clr_n/ff_pre_n all 1 and ff_en=0; done pulses in that cycle; IDLE on the next cycle.
- REQ-023 ff_clr_n and ff_pre_n shall never both be low on any bit in any cycle.
- REQ-024 A zero mask still executes the full CLEAR/PRESET timing, with no bit asserted.
- REQ-025 No new grant while busy; a req raised in the RECOVER cycle is granted at the first IDLE cycle.
- REQ-026 When not in PULSE, ff_en=0 and ff_clr_n/ff_pre_n are all 1; ff_d holds its last value.

Reset
- REQ-027 clr low shall immediately force: state IDLE, gnt=0, done=0, ff_en=0, ff_d=0, ff_clr_n and ff_pre_n all 1, busy=0, arbiter pointer=0.
- REQ-028 clr asserted mid-PULSE shall abort the operation with no done pulse; requesters re-request after reset.

Configuration
- REQ-029 Macro ASYNC_CTL_SEQ_RR_EN defined: round-robin arbitration; after each grant the pointer moves to the granted index+1 (mod NREQ), and the search starts from the pointer.
- REQ-030 Macro ASYNC_CTL_SEQ_RR_EN undefined: fixed priority, lowest index wins; pointer logic is absent.

Structure
- REQ-031 Package async_ctl_pkg shall hold the opcode enum, the state enum and default parameter constants.
- REQ-032 Arbitration shall sit in one sub-module, async_ctl_arb (req and pointer in, one-hot grant out), instantiated once.

Verification
- REQ-033 Reset then req[0]=1, op=CLEAR, mask=8'hF0, PULSE_CYC=2 -> gnt[0] at T; ff_clr_n=8'h0F at T+1..T+2; done[0] at T+3; busy low at T+4.
- REQ-034 req[2]=1, op=LOAD, data=8'hA5 -> ff_en=1, ff_d=8'hA5 at T+1 only; done[2] at T+2.
- REQ-035 req=4'b1111, all NOP, with RR_EN -> grants in order 0,1,2,3,0 at 2-cycle spacing; without RR_EN -> index 0 repeatedly while req[0] is held.
- REQ-036 PRESET mask=8'hFF, clr pulsed low at T+1 -> ff_pre_n=8'hFF, busy=0 and no done in the same cycle; idle after release.
- REQ-037 Random back-to-back ops for 10k cycles -> assertion that no bit ever has ff_clr_n and ff_pre_n both low, and exactly one done per gnt.
